// File: rtl/fpu_add_issuer.sv
// fpu_add_issuer
// Buffers host operand pairs in a small FIFO and issues them one at a time
// to an external floating-point adder with a fixed pipeline latency, then
// holds each result for the host until it is taken.
//
// Parameters
//   DEPTH  operand FIFO entries (power of two, 2..16)
//   LAT    WAIT cycles between the fpu_dval strobe and result capture (1..15)
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   in_valid/in_ready               host push handshake (in_ready = !full)
//   in_a, in_b, in_op               operand pair and operation (0 add, 1 sub)
//   fpu_a, fpu_b, fpu_dval          registered operands and issue strobe to adder
//   fpu_out                         adder result (registered inside the adder)
//   res_valid/res_ready, res_data   result handshake towards the host
//   count                           FIFO occupancy
//   busy                            FSM not idle, or operands still queued
//
// Optional feature
//   FPU_ADD_ISSUER_SUB_EN  when defined, in_op is stored with each pair and a
//                          subtract request flips the sign of operand B on
//                          its way to the adder. When undefined, in_op is
//                          ignored and B is passed through unchanged.

module fpu_add_issuer #(
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic                     in_op,
  output logic [31:0]              fpu_a,
  output logic [31:0]              fpu_b,
  output logic                     fpu_dval,
  input  logic [31:0]              fpu_out,
  output logic                     res_valid,
  output logic [31:0]              res_data,
  input  logic                     res_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef FPU_ADD_ISSUER_SUB_EN
  localparam int EW = 65;   // {op, a, b}
`else
  localparam int EW = 64;   // {a, b}
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // ------------------------------------------------------------------
  // Operand FIFO
  // ------------------------------------------------------------------
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic [31:0]   head_a;
  logic [31:0]   head_b;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  // Full blocks the push even when a pop frees a slot on the same edge.
  assign push  = in_valid && !full;

`ifdef FPU_ADD_ISSUER_SUB_EN
  assign wr_entry = {in_op, in_a, in_b};
`else
  assign wr_entry = {in_a, in_b};
  logic op_unused;
  assign op_unused = in_op;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  assign head   = mem[rd_ptr_reg];
  assign head_a = head[63:32];
`ifdef FPU_ADD_ISSUER_SUB_EN
  // A - B is issued as A + (-B): flip only the sign bit of B.
  assign head_b = head[31:0] ^ {head[64], 31'b0};
`else
  assign head_b = head[31:0];
`endif

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Issue FSM
  // ------------------------------------------------------------------
  state_t      state_reg;
  state_t      state_next;
  logic [3:0]  wait_reg;
  logic        res_valid_reg;
  logic [31:0] res_data_reg;
  logic [31:0] fpu_a_reg;
  logic [31:0] fpu_b_reg;
  logic        fpu_dval_reg;
  logic        dval_next;
  logic        wait_load;
  logic        capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      // A pending result blocks the next issue: one operation in flight.
      IDLE:    if (!empty && !res_valid_reg) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (wait_reg == 4'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    wait_load = 1'b0;
    capture   = 1'b0;
    dval_next = 1'b0;
    if (state_reg == IDLE && state_next == ISSUE) pop = 1'b1;
    if (state_reg == ISSUE) wait_load = 1'b1;
    if (state_reg == WAIT && wait_reg == 4'd1) capture = 1'b1;
    // Strobe is registered so it is high exactly while the FSM sits in ISSUE.
    if (state_next == ISSUE) dval_next = 1'b1;
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_a_reg    <= '0;
      fpu_b_reg    <= '0;
      fpu_dval_reg <= 1'b0;
      wait_reg     <= '0;
    end else begin
      fpu_dval_reg <= dval_next;
      // Operands are only reloaded on a pop, so they stay stable until capture.
      if (pop) begin
        fpu_a_reg <= head_a;
        fpu_b_reg <= head_b;
      end
      if (wait_load) begin
        wait_reg <= 4'(LAT);
      end else if (state_reg == WAIT) begin
        wait_reg <= wait_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      // Capture and consumption never coincide: no capture while res_valid is high.
      if (capture) begin
        res_valid_reg <= 1'b1;
        res_data_reg  <= fpu_out;
      end else if (res_valid_reg && res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign in_ready  = !full;
  assign fpu_a     = fpu_a_reg;
  assign fpu_b     = fpu_b_reg;
  assign fpu_dval  = fpu_dval_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign count     = count_reg;
  assign busy      = (state_reg != IDLE) || !empty;

endmodule

// File: doc/fpu_add_issuer.md
FPU_ADD_ISSUER -- requirements
Module: fpu_add_issuer

Interface
REQ-001 Parameter DEPTH, default 4, sets the operand FIFO entry count, a power of two between 2 and 16.
REQ-002 Parameter LAT, default 1, sets the number of WAIT cycles between the fpu_dval pulse and result capture, between 1 and 15.
REQ-003 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  host operand pair valid.
REQ-006 in_ready  out  1  FIFO can accept; equals !full.
REQ-007 in_a  in  32  IEEE-754 single operand A.
REQ-008 in_b  in  32  IEEE-754 single operand B.
REQ-009 in_op  in  1  0 = add, 1 = subtract (see Configuration).
REQ-010 fpu_a  out  32  operand A to adder, registered.
REQ-011 fpu_b  out  32  operand B to adder, registered.
REQ-012 fpu_dval  out  1  one-cycle issue strobe to adder, registered.
REQ-013 fpu_out  in  32  registered adder result.
REQ-014 res_valid  out  1  result available.
REQ-015 res_data  out  32  captured result.
REQ-016 res_ready  in  1  host consumes result.
REQ-017 count  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-018 busy  out  1  high in any state other than IDLE, or when the FIFO is non-empty.

Function
REQ-019 A push occurs when in_valid and in_ready are both high; it stores {in_op, in_a, in_b} at the FIFO tail.
REQ-020 When the FIFO is full, in_ready is low and no push occurs, even if a pop happens in the same cycle.
REQ-021 The state machine has three states: IDLE, ISSUE and WAIT.
REQ-022 IDLE -> ISSUE when the FIFO is non-empty and res_valid is low; the same edge pops the FIFO head into fpu_a and fpu_b.
REQ-023 ISSUE drives fpu_dval=1 for exactly one cycle, then goes to WAIT and loads the wait counter with LAT.
REQ-024 WAIT decrements the wait counter each cycle; at the edge ending the LAT-th WAIT cycle it captures fpu_out into res_data, sets res_valid, and returns to IDLE.
REQ-025 With LAT=1: dval is high in cycle t, capture occurs at the end of t+1, and res_valid is high from cycle t+2.
REQ-026 fpu_a and fpu_b stay stable from ISSUE until capture; fpu_dval is low in every state except ISSUE.
REQ-027 res_valid and res_data hold until res_valid and res_ready are both high; res_valid clears on the following edge.
REQ-028 No new issue occurs while res_valid is high, so at most one operation is in flight.
REQ-029 A simultaneous push and pop updates count by net zero; the FIFO pointers wrap modulo DEPTH.
REQ-030 Result ordering equals push ordering.

Reset
REQ-031 On rst, the state goes to IDLE, the FIFO is emptied (count=0), and fpu_a, fpu_b, res_data are 0.
REQ-032 On rst, fpu_dval, res_valid and busy are 0, and in_ready is 1 from the first cycle after reset.
REQ-033 A reset during ISSUE or WAIT discards the in-flight operation; no res_valid is produced for it.

Configuration
REQ-034 The macro FPU_ADD_ISSUER_SUB_EN enables subtract support.
REQ-035 When FPU_ADD_ISSUER_SUB_EN is defined and in_op=1, the block drives fpu_b with bit 31 inverted, so the adder computes A-B.
REQ-036 When FPU_ADD_ISSUER_SUB_EN is undefined, in_op is ignored, the op bit is not stored, and fpu_b = in_b unchanged.

Verification
REQ-037 Push A=0x3F800000, B=0x40000000, op=0 with res_ready=1 -> fpu_dval high exactly one cycle, res_data=0x40400000, and res_valid high 2 cycles after dval (LAT=1).
REQ-038 With the macro defined, push A=0x40400000, B=0x3F800000, op=1 -> fpu_b=0xBF800000, res_data=0x40000000; with the macro undefined -> res_data=0x40800000.
REQ-039 Push 5 pairs back-to-back with res_ready=0 and DEPTH=4 -> first issued, count reaches 4, in_ready low, no second dval until the result is taken.
REQ-040 Hold res_ready=0 for 10 cycles after the first result -> res_valid and res_data stable; raising res_ready then releases in-order results with no loss.
REQ-041 Assert rst in the WAIT cycle -> no res_valid, and count=0, fpu_dval=0, in_ready=1 on the next cycle.
REQ-042 Push on the same cycle as a pop with count=2 -> count stays 2, data order preserved across pointer wrap.
